// File: rtl/raster_engine.sv
// rtl/raster_engine.sv - raster command responder: POINT/LINE/RECT/FILL to framebuffer writes
package common;
    typedef enum logic [2:0] {
        CMD_POINT = 3'd1,
        CMD_LINE  = 3'd2,
        CMD_RECT  = 3'd3,
        CMD_FILL  = 3'd4
    } raster_command_t;
endpackage

module raster_engine
    import common::*;
#(
    parameter int WIDTH  = 214,
    parameter int HEIGHT = 160,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_sync,
    input  raster_command_t       gpu_command,
    input  logic [7:0]            gpu_x0,
    input  logic [7:0]            gpu_y0,
    input  logic [7:0]            gpu_x1,
    input  logic [7:0]            gpu_y1,
    input  logic [2:0]            gpu_colour,
    input  logic                  gpu_execute_request,
    output logic                  gpu_busy,
    output logic [ADDR_W-1:0]     fb_addr,
    output logic [2:0]            fb_colour,
    output logic                  fb_write_en
);

    typedef enum logic [2:0] {S_IDLE, S_POINT, S_LINE, S_RECT, S_FILL} state_t;

    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    state_t             state;
    logic [7:0]         cx, cy;
    logic [7:0]         ex, ey;
    logic [7:0]         xl, xh, yh;
    logic               sx_neg, sy_neg;
    logic signed [11:0] dx, dy, err;
    logic [ADDR_W-1:0]  fill_cnt;

    logic [7:0]         rq_dx, rq_dy, rq_xl, rq_xh, rq_yl, rq_yh;
    logic signed [11:0] e2, ln_err;
    logic [7:0]         ln_x, ln_y, rc_x, rc_y;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [7:0] y);
        return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
    endfunction

    function automatic logic in_view(input logic [7:0] x, input logic [7:0] y);
        return (int'(x) < WIDTH) && (int'(y) < HEIGHT);
    endfunction

    always_comb begin
        rq_dx = (gpu_x1 >= gpu_x0) ? gpu_x1 - gpu_x0 : gpu_x0 - gpu_x1;
        rq_dy = (gpu_y1 >= gpu_y0) ? gpu_y1 - gpu_y0 : gpu_y0 - gpu_y1;
        rq_xl = (gpu_x1 >= gpu_x0) ? gpu_x0 : gpu_x1;
        rq_xh = (gpu_x1 >= gpu_x0) ? gpu_x1 : gpu_x0;
        rq_yl = (gpu_y1 >= gpu_y0) ? gpu_y0 : gpu_y1;
        rq_yh = (gpu_y1 >= gpu_y0) ? gpu_y1 : gpu_y0;
    end

    // Bresenham step; both axis tests use the same e2 taken before either update
    always_comb begin
        e2     = err <<< 1;
        ln_err = err;
        ln_x   = cx;
        ln_y   = cy;
        if (e2 >= dy) begin
            ln_err = ln_err + dy;
            ln_x   = sx_neg ? cx - 8'd1 : cx + 8'd1;
        end
        if (e2 <= dx) begin
            ln_err = ln_err + dx;
            ln_y   = sy_neg ? cy - 8'd1 : cy + 8'd1;
        end
    end

    always_comb begin
        rc_x = cx + 8'd1;
        rc_y = cy;
        if (cx == xh) begin
            rc_x = xl;
            rc_y = cy + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state       <= S_IDLE;
            gpu_busy    <= 1'b0;
            fb_write_en <= 1'b0;
            fb_addr     <= '0;
            fb_colour   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    gpu_busy    <= 1'b0;
                    fb_write_en <= 1'b0;
                    if (gpu_execute_request) begin
                        gpu_busy  <= 1'b1;
                        fb_colour <= gpu_colour;
                        ex        <= gpu_x1;
                        ey        <= gpu_y1;
                        xl        <= rq_xl;
                        xh        <= rq_xh;
                        yh        <= rq_yh;
                        sx_neg    <= gpu_x1 < gpu_x0;
                        sy_neg    <= gpu_y1 < gpu_y0;
                        dx        <= 12'(rq_dx);
                        dy        <= -12'(rq_dy);
                        err       <= 12'(rq_dx) - 12'(rq_dy);
                        fill_cnt  <= '0;
                        case (gpu_command)
                            CMD_POINT, CMD_LINE: begin
                                cx          <= gpu_x0;
                                cy          <= gpu_y0;
                                fb_write_en <= in_view(gpu_x0, gpu_y0);
                                fb_addr     <= pix_addr(gpu_x0, gpu_y0);
                                state       <= (gpu_command == CMD_LINE) ? S_LINE : S_POINT;
                            end
                            CMD_RECT: begin
                                cx          <= rq_xl;
                                cy          <= rq_yl;
                                fb_write_en <= in_view(rq_xl, rq_yl);
                                fb_addr     <= pix_addr(rq_xl, rq_yl);
                                state       <= S_RECT;
                            end
                            CMD_FILL: begin
                                fb_write_en <= 1'b1;
                                fb_addr     <= '0;
                                state       <= S_FILL;
                            end
                            // Unknown command: a single silent busy cycle
                            default: state <= S_POINT;
                        endcase
                    end
                end
                S_POINT: begin
                    state       <= S_IDLE;
                    gpu_busy    <= 1'b0;
                    fb_write_en <= 1'b0;
                end
                S_LINE: begin
                    if (cx == ex && cy == ey) begin
                        state       <= S_IDLE;
                        gpu_busy    <= 1'b0;
                        fb_write_en <= 1'b0;
                    end else begin
                        cx          <= ln_x;
                        cy          <= ln_y;
                        err         <= ln_err;
                        fb_write_en <= in_view(ln_x, ln_y);
                        fb_addr     <= pix_addr(ln_x, ln_y);
                    end
                end
                S_RECT: begin
                    if (cx == xh && cy == yh) begin
                        state       <= S_IDLE;
                        gpu_busy    <= 1'b0;
                        fb_write_en <= 1'b0;
                    end else begin
                        cx          <= rc_x;
                        cy          <= rc_y;
                        fb_write_en <= in_view(rc_x, rc_y);
                        fb_addr     <= pix_addr(rc_x, rc_y);
                    end
                end
                S_FILL: begin
                    if (fill_cnt == FILL_LAST) begin
                        state       <= S_IDLE;
                        gpu_busy    <= 1'b0;
                        fb_write_en <= 1'b0;
                    end else begin
                        fill_cnt    <= fill_cnt + 1'b1;
                        fb_addr     <= fill_cnt + 1'b1;
                        fb_write_en <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    gpu_busy    <= 1'b0;
                    fb_write_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
